// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: turns hazard-unit stall/flush requests and the
// data-memory handshake into per-stage register enables and bubble inserts.
// It freezes the pipe while memory is busy, traps into a sticky fault if memory
// never answers, and keeps stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             EnF,
  output logic             EnD,
  output logic             EnE,
  output logic             EnM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // A zero TIMEOUT disables the trap but still needs a 1-bit counter.
  localparam int unsigned WaitW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StFault
  } state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;

  // Mealy enables and flushes; outputs are forced low while reset is held.
  always_comb begin
    EnF    = 1'b1;
    EnD    = 1'b1;
    EnE    = 1'b1;
    EnM    = 1'b1;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    case (state_q)
      StFault: begin
        {EnF, EnD, EnE, EnM}    = 4'b0000;
        {FlushD, FlushE, FlushW} = 3'b111;
      end
      default: begin
        // In MEM_WAIT only mem_ready matters; in RUN a missed access starts the freeze.
        if ((state_q == StMemWait) ? !mem_ready : (mem_req && !mem_ready)) begin
          {EnF, EnD, EnE, EnM} = 4'b0000;
          FlushW               = 1'b1;
        end else if (flush_req) begin
          // Flush wins over stall: the stalled instruction in D is discarded anyway.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (stall_req) begin
          EnF    = 1'b0;
          EnD    = 1'b0;
          FlushE = 1'b1;
        end
      end
    endcase
    if (!rst_n) begin
      {EnF, EnD, EnE, EnM}    = 4'b0000;
      {FlushD, FlushE, FlushW} = 3'b000;
    end
  end

  // Control FSM: memory-wait tracking with timeout and the sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      fault      <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_req && !mem_ready) begin
            state_q    <= StMemWait;
            wait_cnt_q <= '0;
          end
        end
        StMemWait: begin
          // mem_ready beats the timeout when both land in the same cycle.
          if (mem_ready) begin
            state_q <= StRun;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
            if ((TIMEOUT != 0) && (wait_cnt_q == WaitLast)) begin
              state_q <= StFault;
              fault   <= 1'b1;
            end
          end
        end
        StFault: begin
          // Only reset leaves the fault state.
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Performance counters; frozen in the fault state, wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q != StFault) begin
      if (!EnD) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (FlushD) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequences the five-stage pipeline registers (F/D, D/E, E/M, M/W) from the hazard unit's stall/flush requests and the data-memory handshake. Produces per-stage enables and flushes, freezes the pipe on a memory wait, and traps into a sticky fault on memory timeout. Maintains stall and flush performance counters. Sits beside the hazard unit in the core top level, between the hazard logic and the pipeline registers.

## Interface
- `TIMEOUT`, default 64: maximum cycles in MEM_WAIT before fault; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  core clock; the single clock of the block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `stall_req`  in  1  load-use stall request from the hazard unit.
- `flush_req`  in  1  branch-taken/jump flush request from the hazard unit.
- `mem_req`  in  1  instruction in M is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `EnF`, `EnD`, `EnE`, `EnM`  out  1 each  enables for the PC, F/D, D/E and E/M registers.
- `FlushD`, `FlushE`, `FlushW`  out  1 each  insert a bubble into F/D, D/E or M/W.
- `fault`  out  1  sticky memory-timeout fault.
- `stall_cnt`  out  CNT_W  cycles with `EnD`=0 while not in FAULT.
- `flush_cnt`  out  CNT_W  cycles with `FlushD`=1.

## Operation
- States: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- Outputs are Mealy (combinational from state and inputs). The defaults are all enables 1 and all flushes 0. One decision applies per cycle, in the priority order below.
- RUN, `mem_req`=1 and `mem_ready`=0:
  - En* = 0 and FlushW = 1.
  - Next state MEM_WAIT. `wait_cnt` clears to 0.
- RUN, otherwise, with `flush_req`=1:
  - FlushD = 1 and FlushE = 1. All enables stay 1.
  - Flush overrides stall, because the stalled instruction in D is discarded anyway.
- RUN, otherwise, with `stall_req`=1: EnF = 0, EnD = 0, FlushE = 1.
- MEM_WAIT, `mem_ready`=0:
  - Outputs are the same as on MEM_WAIT entry.
  - `wait_cnt` increments.
  - If `TIMEOUT`≠0 and `wait_cnt`==`TIMEOUT`-1, next state is FAULT.
- MEM_WAIT, `mem_ready`=1:
  - Next state RUN.
  - Outputs this cycle are the RUN decision with the memory condition treated as satisfied, so the held `flush_req`/`stall_req` take effect on the release cycle.
  - `mem_ready` beats the timeout in the same cycle.
- FAULT:
  - En* = 0, FlushD = FlushE = FlushW = 1, `fault` = 1.
  - Exited only by reset. Inputs are ignored and the counters freeze.
- `wait_cnt` is internal and ⌈log2(TIMEOUT+1)⌉ bits wide, minimum 1.
- `stall_cnt` and `flush_cnt` increment by 1 on qualifying cycles and wrap modulo 2^CNT_W with no saturation.

## Timing
- While `rst_n`=0, asynchronously:
  - state = RUN, `wait_cnt` = 0, `fault` = 0, `stall_cnt` = 0, `flush_cnt` = 0.
  - En* = 0 and all flushes = 0 (outputs forced).
- Reset release takes effect at the first `clk` rising edge with `rst_n`=1. From that cycle, outputs follow the RUN rules.
- Zero-cycle latency from `stall_req`/`flush_req`/`mem_req`/`mem_ready` to the enables and flushes.
- State, `wait_cnt`, `fault` and the counters update on the rising edge of `clk`.
- A memory wait of N cycles (N ≥ 1 cycles with `mem_ready`=0, then ready) freezes the pipe for exactly N cycles. The ready cycle has all enables 1 unless a stall applies.
- A single-cycle access (`mem_req`=`mem_ready`=1 in RUN) causes no freeze and no state change.
- Reset asserted mid-MEM_WAIT or in FAULT returns to RUN immediately, and `fault` deasserts asynchronously.
- `fault` rises at the edge ending the `TIMEOUT`-th consecutive MEM_WAIT cycle.

## Test plan
- **Load-use stall:** RUN, `stall_req`=1 for 1 cycle → that cycle EnF=EnD=0, FlushE=1, EnE=EnM=1; then `stall_cnt`=1 and `flush_cnt`=0.
- **Flush beats stall:** `flush_req`=`stall_req`=1 for 1 cycle → FlushD=FlushE=1, all En=1; then `flush_cnt`=1 and `stall_cnt`=0.
- **Memory wait:** `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1.
  - The 3 cycles: En*=0, FlushW=1.
  - 4th cycle: all En=1.
  - Then state is RUN and `stall_cnt`=3.
- **Wait with pending flush:** as the memory-wait case, plus `flush_req`=1 throughout → no FlushD during the wait; on the ready cycle FlushD=FlushE=1 with En=1.
- **Timeout:** `TIMEOUT`=4, `mem_req`=1, `mem_ready`=0 held.
  - `fault`=1 after 4 wait cycles, with En*=0 and flushes=1.
  - Later `mem_ready`=1 has no effect.
  - Asserting `rst_n`=0 clears `fault` and both counters to 0.
  - Variant: `mem_ready`=1 on the 4th wait cycle → RUN, `fault` stays 0.
- **Counter wrap:** `CNT_W`=4, 17 consecutive stall cycles → `stall_cnt`=1.
